// File: rtl/game_flow_ctrl.sv
// Blobby Volley match sequencer: serve, rally, point pause and game over.
// Counts touches per side, awards points and drives ball hold/serve.
module game_flow_ctrl #(
  parameter int WIN_SCORE   = 15,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_PAUSE = 90,
  parameter int MAX_TOUCH   = 3,
  parameter int NET_X       = 512
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start,
  input  logic        gnd_col,
  input  logic        pl1_col,
  input  logic        pl2_col,
  input  logic [11:0] ball_xpos,
  output logic        ball_hold,
  output logic        ball_serve,
  output logic        serve_side,
  output logic [3:0]  score_pl1,
  output logic [3:0]  score_pl2,
  output logic        point_pulse,
  output logic        last_touch,
  output logic        thirdtouched,
  output logic        endgame,
  output logic [2:0]  state
);

  localparam int FMAX = (SERVE_DELAY > POINT_PAUSE) ? SERVE_DELAY : POINT_PAUSE;
  localparam int FW   = $clog2(FMAX + 1);
  localparam logic [FW-1:0] SD_END = FW'(SERVE_DELAY - 1);
  localparam logic [FW-1:0] PP_END = FW'(POINT_PAUSE - 1);
  localparam logic [2:0]    T_MAX  = 3'(MAX_TOUCH);
  localparam logic [2:0]    T_FLT  = 3'(MAX_TOUCH + 1);
  localparam logic [3:0]    W_SC   = 4'(WIN_SCORE);
  localparam logic [11:0]   NET    = 12'(NET_X);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t st, st_n;
  logic [4:0] in_q, in_d, ev;
  logic tick, start_e, gnd_e, pl1_e, pl2_e;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [2:0] tcnt, tcnt_n, t_cnt;
  logic [3:0] s1_n, s2_n, win_sc;
  logic side_n, last_n, third_n, serve_n, pp_n;
  logic award, winner, t_side;

  // one register stage, then rising edge of the registered level
  assign ev = in_q & ~in_d;
  assign {tick, start_e, gnd_e, pl1_e, pl2_e} = ev;
  assign state = st;
  assign win_sc = serve_side ? score_pl2 : score_pl1;

  always_comb begin
    st_n    = st;
    fcnt_n  = fcnt;
    tcnt_n  = tcnt;
    s1_n    = score_pl1;
    s2_n    = score_pl2;
    side_n  = serve_side;
    last_n  = last_touch;
    third_n = thirdtouched;
    serve_n = 1'b0;
    pp_n    = 1'b0;
    award   = 1'b0;
    winner  = 1'b0;
    t_side  = pl2_e;
    t_cnt   = 3'd1;
    unique case (st)
      IDLE: begin
        if (start_e) begin
          side_n  = 1'b0;
          st_n    = SERVE;
          fcnt_n  = '0;
          serve_n = 1'b1;
        end
      end
      SERVE: begin
        if (tick) begin
          if (fcnt == SD_END) begin
            st_n    = RALLY;
            tcnt_n  = 3'd0;
            third_n = 1'b0;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end
      RALLY: begin
        if (gnd_e) begin
          award  = 1'b1;
          winner = (ball_xpos < NET) ? 1'b1 : 1'b0;
        end else if (pl1_e ^ pl2_e) begin
          if (last_touch == t_side)
            t_cnt = (tcnt == T_FLT) ? tcnt : tcnt + 3'd1;
          last_n  = t_side;
          tcnt_n  = t_cnt;
          third_n = (t_cnt == T_MAX);
          if (t_cnt == T_FLT) begin
            award  = 1'b1;
            winner = ~t_side;
          end
        end
        if (award) begin
          if (winner) s2_n = (score_pl2 == W_SC) ? score_pl2 : score_pl2 + 4'd1;
          else        s1_n = (score_pl1 == W_SC) ? score_pl1 : score_pl1 + 4'd1;
          side_n = winner;
          pp_n   = 1'b1;
          st_n   = POINT;
          fcnt_n = '0;
        end
      end
      POINT: begin
        if (tick) begin
          if (fcnt == PP_END) begin
            fcnt_n = '0;
            if (win_sc == W_SC) begin
              st_n = OVER;
            end else begin
              st_n    = SERVE;
              serve_n = 1'b1;
            end
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end
      OVER: begin
        if (start_e) begin
          s1_n    = 4'd0;
          s2_n    = 4'd0;
          side_n  = 1'b0;
          st_n    = SERVE;
          fcnt_n  = '0;
          serve_n = 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      in_q         <= '0;
      in_d         <= '0;
      st           <= IDLE;
      fcnt         <= '0;
      tcnt         <= 3'd0;
      score_pl1    <= 4'd0;
      score_pl2    <= 4'd0;
      serve_side   <= 1'b0;
      last_touch   <= 1'b0;
      thirdtouched <= 1'b0;
      ball_serve   <= 1'b0;
      point_pulse  <= 1'b0;
      ball_hold    <= 1'b1;
      endgame      <= 1'b0;
    end else begin
      in_q         <= {vblnk, start, gnd_col, pl1_col, pl2_col};
      in_d         <= in_q;
      st           <= st_n;
      fcnt         <= fcnt_n;
      tcnt         <= tcnt_n;
      score_pl1    <= s1_n;
      score_pl2    <= s2_n;
      serve_side   <= side_n;
      last_touch   <= last_n;
      thirdtouched <= third_n;
      ball_serve   <= serve_n;
      point_pulse  <= pp_n;
      ball_hold    <= (st_n != RALLY);
      endgame      <= (st_n == OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scoreboard bench for game_flow_ctrl.
// Expected snapshots are queued with each step and popped for comparison.
module tb_game_flow_ctrl;

  logic pclk = 1'b0;
  logic rst, vblnk, start, gnd_col, pl1_col, pl2_col;
  logic [11:0] ball_xpos;
  logic ball_hold, ball_serve, serve_side, point_pulse;
  logic last_touch, thirdtouched, endgame;
  logic [3:0] score_pl1, score_pl2;
  logic [2:0] state;

  game_flow_ctrl dut (
    .pclk(pclk), .rst(rst), .vblnk(vblnk), .start(start),
    .gnd_col(gnd_col), .pl1_col(pl1_col), .pl2_col(pl2_col),
    .ball_xpos(ball_xpos), .ball_hold(ball_hold),
    .ball_serve(ball_serve), .serve_side(serve_side),
    .score_pl1(score_pl1), .score_pl2(score_pl2),
    .point_pulse(point_pulse), .last_touch(last_touch),
    .thirdtouched(thirdtouched), .endgame(endgame), .state(state)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;
  int n_serve = 0;
  int n_point = 0;

  always @(negedge pclk) begin
    if (ball_serve === 1'b1) n_serve++;
    if (point_pulse === 1'b1) n_point++;
  end

  typedef struct {
    string tag;
    logic [2:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic side;
    logic last;
    logic third;
    int nsv;
    int npt;
  } snap_t;

  snap_t q[$];
  logic [3:0] e_s1, e_s2;
  logic e_side;
  int e_nsv, e_npt;

  task automatic cmp(string name, logic [15:0] o, logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, o, e);
    end
  endtask

  task automatic push(string tag, logic [2:0] st, logic last, logic third);
    snap_t s;
    s.tag = tag; s.st = st; s.s1 = e_s1; s.s2 = e_s2;
    s.side = e_side; s.last = last; s.third = third;
    s.nsv = e_nsv; s.npt = e_npt;
    q.push_back(s);
  endtask

  task automatic check();
    snap_t s;
    s = q.pop_front();
    cmp({s.tag, ".state"}, 16'(state), 16'(s.st));
    cmp({s.tag, ".s1"}, 16'(score_pl1), 16'(s.s1));
    cmp({s.tag, ".s2"}, 16'(score_pl2), 16'(s.s2));
    cmp({s.tag, ".side"}, 16'(serve_side), 16'(s.side));
    cmp({s.tag, ".last"}, 16'(last_touch), 16'(s.last));
    cmp({s.tag, ".third"}, 16'(thirdtouched), 16'(s.third));
    cmp({s.tag, ".hold"}, 16'(ball_hold), 16'(s.st != 3'd2));
    cmp({s.tag, ".endg"}, 16'(endgame), 16'(s.st == 3'd4));
    cmp({s.tag, ".nserve"}, 16'(n_serve), 16'(s.nsv));
    cmp({s.tag, ".npoint"}, 16'(n_point), 16'(s.npt));
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic ev(bit s, bit g, bit p1, bit p2, logic [11:0] x);
    ball_xpos = x;
    start = s; gnd_col = g; pl1_col = p1; pl2_col = p2;
    cyc(2);
    start = 0; gnd_col = 0; pl1_col = 0; pl2_col = 0;
    cyc(3);
  endtask

  task automatic frames(int n);
    repeat (n) begin
      vblnk = 1'b1;
      cyc(2);
      vblnk = 1'b0;
      cyc(2);
    end
  endtask

  initial begin
    rst = 0; vblnk = 0; start = 0; gnd_col = 0;
    pl1_col = 0; pl2_col = 0; ball_xpos = 12'd0;
    e_s1 = 0; e_s2 = 0; e_side = 0; e_nsv = 0; e_npt = 0;
    cyc(3);
    push("reset", 3'd0, 0, 0); check();
    rst = 1;
    cyc(2);

    ev(1, 0, 0, 0, 12'd0);
    e_nsv = 1;
    push("start", 3'd1, 0, 0); check();
    frames(59);
    push("serve59", 3'd1, 0, 0); check();
    frames(1);
    push("rally", 3'd2, 0, 0); check();

    ev(0, 1, 0, 0, 12'd300);
    e_s2 = 1; e_side = 1; e_npt = 1;
    push("gnd300", 3'd3, 0, 0); check();
    frames(89);
    push("pause89", 3'd3, 0, 0); check();
    frames(1);
    e_nsv = 2;
    push("reserve", 3'd1, 0, 0); check();
    frames(60);
    push("rally2", 3'd2, 0, 0); check();

    ev(0, 0, 1, 0, 12'd100);
    push("t1", 3'd2, 0, 0); check();
    ev(0, 0, 1, 0, 12'd100);
    push("t2", 3'd2, 0, 0); check();
    ev(0, 0, 1, 0, 12'd100);
    push("t3", 3'd2, 0, 1); check();
    ev(0, 0, 1, 0, 12'd100);
    e_s2 = 2; e_side = 1; e_npt = 2;
    push("t4fault", 3'd3, 0, 0); check();
    frames(90);
    e_nsv = 3;
    frames(60);
    push("rally3", 3'd2, 0, 0); check();

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) ev(0, 0, 0, 1, 12'd600);
      else            ev(0, 0, 1, 0, 12'd100);
      push($sformatf("alt%0d", i), 3'd2, (i % 2 == 0), 0); check();
    end
    ev(0, 0, 1, 1, 12'd500);
    push("both", 3'd2, 0, 0); check();
    ev(1, 0, 0, 0, 12'd500);
    push("start_rally", 3'd2, 0, 0); check();

    ev(0, 1, 0, 1, 12'd700);
    e_s1 = 1; e_side = 0; e_npt = 3;
    push("gnd_pl2", 3'd3, 0, 0); check();
    frames(90);
    e_nsv = 4;
    frames(60);
    push("rally4", 3'd2, 0, 0); check();

    for (int i = 2; i <= 14; i++) begin
      ev(0, 1, 0, 0, 12'd700);
      e_s1 = 4'(i); e_npt++;
      push($sformatf("pt%0d", i), 3'd3, 0, 0); check();
      frames(90);
      e_nsv++;
      frames(60);
    end
    ev(0, 1, 0, 0, 12'd900);
    e_s1 = 15; e_npt++;
    push("pt15", 3'd3, 0, 0); check();
    frames(90);
    push("over", 3'd4, 0, 0); check();
    ev(0, 1, 0, 0, 12'd100);
    push("over_gnd", 3'd4, 0, 0); check();
    ev(1, 0, 0, 0, 12'd100);
    e_s1 = 0; e_s2 = 0; e_side = 0; e_nsv++;
    push("restart", 3'd1, 0, 0); check();

    frames(60);
    push("rally5", 3'd2, 0, 0); check();
    ev(0, 0, 0, 1, 12'd600);
    push("pre_rst", 3'd2, 1, 0); check();
    @(posedge pclk);
    #2 rst = 0;
    #1;
    push("async_rst", 3'd0, 0, 0); check();
    cyc(2);
    rst = 1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
